// File: rtl/mse_metric_sink.sv
// Windowed mean-squared-error sink: accumulates (ref-apx)^2 over 2^N_LOG2 pairs.
// Define MSE_MAXERR_EN to add the peak |ref-apx| tracker and max_abs_err port.
module mse_metric_sink #(
  parameter int W      = 16,
  parameter int N_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic signed [W-1:0]   ref_sample,
  input  logic signed [W-1:0]   apx_sample,
  output logic                  busy,
  output logic                  done,
  output logic [2*W-1:0]        mse,
`ifdef MSE_MAXERR_EN
  output logic [W:0]            max_abs_err,
`endif
  output logic [2*W+N_LOG2-1:0] sum_sq
);

  localparam int AW = 2*W + N_LOG2;
  localparam logic [N_LOG2:0] WIN_M1 = {1'b0, {N_LOG2{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t              state, state_nx;
  logic [N_LOG2:0]     cnt;
  logic [1:0]          drn;
  logic                fire, last, clr, fin;
  logic [1:0]          vld_pipe;
  logic signed [W:0]   d1;
  logic signed [2*W+1:0] prod;
  logic [2*W-1:0]      sq2;
  logic [AW-1:0]       acc;

  assign fire = s_valid && s_ready;
  assign last = fire && (cnt == WIN_M1);
  assign clr  = start && (state == IDLE || state == DONE);
  assign fin  = (state == DRAIN) && (drn == 2'd2);
  assign prod = d1 * d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = ACCUM;
      ACCUM: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (fin) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = ACCUM;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      drn <= '0;
    end else if (clr) begin
      cnt <= '0;
      drn <= '0;
    end else begin
      if (fire)           cnt <= cnt + 1'b1;
      if (state == DRAIN) drn <= drn + 1'b1;
    end
  end

  // Non-accepted cycles load zero into S1 so bubbles add nothing downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      d1       <= '0;
      sq2      <= '0;
      acc      <= '0;
      mse      <= '0;
      sum_sq   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], fire};
      d1       <= fire ? ($signed({ref_sample[W-1], ref_sample}) -
                          $signed({apx_sample[W-1], apx_sample})) : '0;
      sq2      <= prod[2*W-1:0];
      acc      <= clr ? '0 : acc + (vld_pipe[1] ? AW'(sq2) : '0);
      if (fin) begin
        sum_sq <= acc;
        mse    <= acc[AW-1:N_LOG2];
      end else if (clr) begin
        sum_sq <= '0;
        mse    <= '0;
      end
    end
  end

`ifdef MSE_MAXERR_EN
  logic [W:0] mx, ad1;

  assign ad1 = d1[W] ? $unsigned(-d1) : $unsigned(d1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mx          <= '0;
      max_abs_err <= '0;
    end else begin
      if (clr)                          mx <= '0;
      else if (vld_pipe[0] && ad1 > mx) mx <= ad1;
      if (fin)      max_abs_err <= mx;
      else if (clr) max_abs_err <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_mse_metric_sink.sv
// Scoreboard bench for mse_metric_sink with a 16-pair window (N_LOG2=4).
module tb_mse_metric_sink;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int NP = 1 << N;
  localparam int AW = 2*W + N;

  logic clk = 1'b0;
  logic rst, start, s_valid, s_ready, busy, done;
  logic signed [W-1:0] ref_s, apx_s;
  logic [2*W-1:0] mse;
  logic [AW-1:0]  sum_sq;
`ifdef MSE_MAXERR_EN
  logic [W:0] max_abs_err;
`endif

  always #5 clk = ~clk;

  mse_metric_sink #(.W(W), .N_LOG2(N)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .ref_sample(ref_s), .apx_sample(apx_s), .busy(busy), .done(done), .mse(mse),
`ifdef MSE_MAXERR_EN
    .max_abs_err(max_abs_err),
`endif
    .sum_sq(sum_sq)
  );

  typedef struct { longint sum; longint mse; int mx; } exp_t;
  exp_t exp_q[$];
  int rq[NP], aq[NP], gcnt[NP];
  int npass = 0, ntot = 0;

  task automatic do_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Entered at a negedge in ACCUM; drives one window, then checks its result.
  task automatic send_window(input string tag, input int start_at);
    exp_t e, got;
    int d, k;
    bit rdy_ok;
    rdy_ok = 1'b1;
    e.sum = 0; e.mx = 0;
    for (int i = 0; i < NP; i++) begin
      for (int g = 0; g < gcnt[i]; g++) begin
        s_valid = 1'b0; start = 1'b0;
        if (s_ready !== 1'b1) rdy_ok = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1; start = (i == start_at);
      ref_s = W'(rq[i]); apx_s = W'(aq[i]);
      if (s_ready !== 1'b1) rdy_ok = 1'b0;
      d = rq[i] - aq[i];
      e.sum += longint'(d) * longint'(d);
      if ((d < 0 ? -d : d) > e.mx) e.mx = (d < 0 ? -d : d);
      @(posedge clk);
      if (i < NP-1) @(negedge clk);
    end
    e.mse = e.sum >>> N;
    exp_q.push_back(e);
    #1; s_valid = 1'b0; start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    ntot++;
    if (k !== 3) $display("FAIL %s latency: got %0d cycles, want 3", tag, k); else npass++;
    ntot++;
    if (rdy_ok !== 1'b1) $display("FAIL %s s_ready: dropped inside window", tag); else npass++;
    got = exp_q.pop_front();
    ntot++;
    if (sum_sq !== AW'(got.sum)) $display("FAIL %s sum_sq: got %0d want %0d", tag, sum_sq, got.sum); else npass++;
    ntot++;
    if (mse !== 32'(got.mse)) $display("FAIL %s mse: got %0d want %0d", tag, mse, got.mse); else npass++;
    ntot++;
    if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", tag, busy); else npass++;
`ifdef MSE_MAXERR_EN
    ntot++;
    if (max_abs_err !== 17'(got.mx)) $display("FAIL %s max_abs_err: got %0d want %0d", tag, max_abs_err, got.mx); else npass++;
`endif
  endtask

  task automatic fill(input int r, input int a);
    for (int i = 0; i < NP; i++) begin rq[i] = r; aq[i] = a; gcnt[i] = 0; end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; ref_s = '0; apx_s = '0;
    #12;
    ntot++; if (s_ready !== 1'b0) $display("FAIL reset s_ready: got %b want 0", s_ready); else npass++;
    ntot++; if (busy !== 1'b0)    $display("FAIL reset busy: got %b want 0", busy); else npass++;
    ntot++; if (done !== 1'b0)    $display("FAIL reset done: got %b want 0", done); else npass++;
    ntot++; if (mse !== '0)       $display("FAIL reset mse: got %0d want 0", mse); else npass++;
    ntot++; if (sum_sq !== '0)    $display("FAIL reset sum_sq: got %0d want 0", sum_sq); else npass++;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    ntot++; if (s_ready !== 1'b0) $display("FAIL idle_wait s_ready: got %b want 0", s_ready); else npass++;
  endtask

  task automatic test_zero_err;
    fill(1234, 1234); do_start; send_window("zero_err", -1);
  endtask

  task automatic test_small_err;
    fill(100, 97); do_start; send_window("small_err", -1);
  endtask

  task automatic test_extreme;
    fill(32767, -32768); do_start; send_window("extreme", -1);
  endtask

  task automatic test_gaps;
    int dv[4] = '{1, -1, 1, 0};
    for (int i = 0; i < NP; i++) begin
      rq[i] = int'($urandom_range(0, 2000)) - 1000;
      aq[i] = rq[i] - (i < 4 ? dv[i] : 0);
      gcnt[i] = 0;
    end
    for (int j = 0; j < 3; j++) gcnt[$urandom_range(1, NP-1)]++;
    do_start; send_window("gaps", -1);
  endtask

  task automatic test_abort;
    do_start;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; ref_s = 16'sd500; apx_s = -16'sd500;
      @(negedge clk);
    end
    s_valid = 1'b0;
    @(posedge clk); #2; rst = 1'b1; #1;
    ntot++; if (s_ready !== 1'b0) $display("FAIL abort s_ready: got %b want 0", s_ready); else npass++;
    ntot++; if (busy !== 1'b0)    $display("FAIL abort busy: got %b want 0", busy); else npass++;
    ntot++; if (done !== 1'b0)    $display("FAIL abort done: got %b want 0", done); else npass++;
    ntot++; if (mse !== '0)       $display("FAIL abort mse: got %0d want 0", mse); else npass++;
    ntot++; if (sum_sq !== '0)    $display("FAIL abort sum_sq: got %0d want 0", sum_sq); else npass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fill(-300, -302); do_start; send_window("after_abort", -1);
  endtask

  task automatic test_start_events;
    for (int i = 0; i < NP; i++) begin
      rq[i] = int'($urandom_range(0, 4000)) - 2000;
      aq[i] = rq[i] + int'($urandom_range(0, 20)) - 10;
      gcnt[i] = 0;
    end
    do_start; send_window("start_mid_accum", 7);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    ntot++; if (done !== 1'b0)    $display("FAIL restart done: got %b want 0", done); else npass++;
    ntot++; if (busy !== 1'b1)    $display("FAIL restart busy: got %b want 1", busy); else npass++;
    ntot++; if (mse !== '0)       $display("FAIL restart mse: got %0d want 0", mse); else npass++;
    ntot++; if (sum_sq !== '0)    $display("FAIL restart sum_sq: got %0d want 0", sum_sq); else npass++;
    @(negedge clk); start = 1'b0;
    fill(7, 12); send_window("restart_window", -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_zero_err;
    test_small_err;
    test_extreme;
    test_gaps;
    test_abort;
    test_start_events;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
